// File: rtl/iic_reg_access_pkg.sv
// Shared definitions for the single-register IIC access sequencer.
// State encoding and the fixed core access-count value live here.
package iic_reg_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_AS_REQ  = 3'd3,
    ST_AS_WAIT = 3'd4,
    ST_RD_REQ  = 3'd5,
    ST_RD_WAIT = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  // Core count 0 means "default length": 2 bytes for a write, 1 byte for a read.
  localparam logic [7:0] IIC_NUM_SINGLE = 8'h00;

endpackage

// File: rtl/iic_reg_access.sv
// Turns one host register request into IIC core transactions: a 2-byte write,
// or an address-set write followed by a 1-byte read, with NACK and watchdog reporting.
module iic_reg_access
  import iic_reg_access_pkg::*;
#(
  parameter int TO_WIDTH = 22
) (
  input  logic       CLK_IN,
  input  logic       RESET_IN,
  input  logic       REG_REQ_IN,
  input  logic       REG_RNW_IN,
  input  logic [6:0] REG_DAD_IN,
  input  logic [7:0] REG_ADR_IN,
  input  logic [7:0] REG_WDT_IN,
  output logic       REG_BSY_OUT,
  output logic       REG_ACK_OUT,
  output logic [7:0] REG_RDT_OUT,
  output logic       REG_ERR_OUT,
  output logic       REG_TMO_OUT,
  output logic       IIC_REQ_OUT,
  output logic       IIC_AST_OUT,
  output logic [7:0] IIC_NUM_OUT,
  output logic [6:0] IIC_DAD_OUT,
  output logic       IIC_RNW_OUT,
  output logic [7:0] IIC_WDT_OUT,
  input  logic       IIC_RAK_IN,
  input  logic       IIC_WDA_IN,
  input  logic       IIC_RVL_IN,
  input  logic [7:0] IIC_RDT_IN,
  input  logic       IIC_BSY_IN,
  input  logic       IIC_ERR_IN
);

  state_t              state;
  logic [6:0]          req_dad;
  logic [7:0]          req_adr;
  logic [7:0]          req_wdt;
  logic                byte_ptr;
  logic [TO_WIDTH-1:0] wdog;
  logic [TO_WIDTH-1:0] wdog_inc;
  logic                wdog_expire;

  assign wdog_inc    = wdog + {{(TO_WIDTH-1){1'b0}}, 1'b1};
  assign wdog_expire = (state != ST_IDLE) && (state != ST_DONE) && (&wdog_inc);

  // The register address goes out first; the pointer switches to the data byte once the core takes it.
  assign IIC_WDT_OUT = byte_ptr ? req_wdt : req_adr;
  assign IIC_DAD_OUT = req_dad;
  assign IIC_NUM_OUT = IIC_NUM_SINGLE;

  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      state       <= ST_IDLE;
      req_dad     <= '0;
      req_adr     <= '0;
      req_wdt     <= '0;
      byte_ptr    <= 1'b0;
      wdog        <= '0;
      REG_BSY_OUT <= 1'b0;
      REG_ACK_OUT <= 1'b0;
      REG_RDT_OUT <= '0;
      REG_ERR_OUT <= 1'b0;
      REG_TMO_OUT <= 1'b0;
      IIC_REQ_OUT <= 1'b0;
      IIC_AST_OUT <= 1'b0;
      IIC_RNW_OUT <= 1'b0;
    end else begin
      REG_ACK_OUT <= 1'b0;
      if (state != ST_IDLE) wdog <= wdog_inc;

      // Timeout abandons the core mid-access; a later request simply waits for its RAK.
      if (wdog_expire) begin
        REG_TMO_OUT <= 1'b1;
        REG_ERR_OUT <= 1'b1;
        IIC_REQ_OUT <= 1'b0;
        REG_ACK_OUT <= 1'b1;
        state       <= ST_DONE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (REG_REQ_IN) begin
              req_dad     <= REG_DAD_IN;
              req_adr     <= REG_ADR_IN;
              req_wdt     <= REG_WDT_IN;
              byte_ptr    <= 1'b0;
              wdog        <= '0;
              REG_ERR_OUT <= 1'b0;
              REG_TMO_OUT <= 1'b0;
              REG_BSY_OUT <= 1'b1;
              IIC_REQ_OUT <= 1'b1;
              IIC_RNW_OUT <= 1'b0;
              IIC_AST_OUT <= REG_RNW_IN;
              state       <= REG_RNW_IN ? ST_AS_REQ : ST_WR_REQ;
            end
          end
          ST_WR_REQ: begin
            if (IIC_RAK_IN) begin
              IIC_REQ_OUT <= 1'b0;
              state       <= ST_WR_WAIT;
            end
          end
          ST_WR_WAIT: begin
            if (IIC_WDA_IN) byte_ptr <= 1'b1;
            if (!IIC_BSY_IN) begin
              REG_ERR_OUT <= IIC_ERR_IN;
              REG_ACK_OUT <= 1'b1;
              state       <= ST_DONE;
            end
          end
          ST_AS_REQ: begin
            if (IIC_RAK_IN) begin
              IIC_REQ_OUT <= 1'b0;
              state       <= ST_AS_WAIT;
            end
          end
          ST_AS_WAIT: begin
            if (!IIC_BSY_IN) begin
              if (IIC_ERR_IN) begin
                REG_ERR_OUT <= 1'b1;
                REG_ACK_OUT <= 1'b1;
                state       <= ST_DONE;
              end else begin
                IIC_AST_OUT <= 1'b0;
                IIC_RNW_OUT <= 1'b1;
                IIC_REQ_OUT <= 1'b1;
                state       <= ST_RD_REQ;
              end
            end
          end
          ST_RD_REQ: begin
            if (IIC_RAK_IN) begin
              IIC_REQ_OUT <= 1'b0;
              state       <= ST_RD_WAIT;
            end
          end
          ST_RD_WAIT: begin
            if (IIC_RVL_IN) REG_RDT_OUT <= IIC_RDT_IN;
            if (!IIC_BSY_IN) begin
              REG_ERR_OUT <= IIC_ERR_IN;
              REG_ACK_OUT <= 1'b1;
              state       <= ST_DONE;
            end
          end
          ST_DONE: begin
            REG_BSY_OUT <= 1'b0;
            state       <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iic_reg_access.sv
// Scoreboard bench for iic_reg_access driven against a behavioural IIC core stub.
// Host responses and core-side transactions are both checked from expectation queues.
module tb_iic_reg_access;

  localparam int TO_W = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       reg_req = 1'b0;
  logic       reg_rnw = 1'b0;
  logic [6:0] reg_dad = '0;
  logic [7:0] reg_adr = '0;
  logic [7:0] reg_wdt = '0;
  logic       reg_bsy, reg_ack, reg_err, reg_tmo;
  logic [7:0] reg_rdt;
  logic       iic_req, iic_ast, iic_rnw;
  logic [7:0] iic_num, iic_wdt;
  logic [6:0] iic_dad;
  logic       iic_rak = 1'b0;
  logic       iic_wda = 1'b0;
  logic       iic_rvl = 1'b0;
  logic [7:0] iic_rdt = '0;
  logic       iic_bsy = 1'b0;
  logic       iic_err = 1'b0;

  logic       stub_hang = 1'b0;
  logic       as_nack = 1'b0;
  logic [7:0] rd_data = '0;
  int         rd_hold = 2;

  int compared = 0;
  int mismatched = 0;
  int ack_count = 0;

  logic [9:0]  sb_exp[$];
  logic [31:0] bus_exp[$];

  iic_reg_access #(.TO_WIDTH(TO_W)) dut (
    .CLK_IN(clock), .RESET_IN(reset),
    .REG_REQ_IN(reg_req), .REG_RNW_IN(reg_rnw), .REG_DAD_IN(reg_dad),
    .REG_ADR_IN(reg_adr), .REG_WDT_IN(reg_wdt),
    .REG_BSY_OUT(reg_bsy), .REG_ACK_OUT(reg_ack), .REG_RDT_OUT(reg_rdt),
    .REG_ERR_OUT(reg_err), .REG_TMO_OUT(reg_tmo),
    .IIC_REQ_OUT(iic_req), .IIC_AST_OUT(iic_ast), .IIC_NUM_OUT(iic_num),
    .IIC_DAD_OUT(iic_dad), .IIC_RNW_OUT(iic_rnw), .IIC_WDT_OUT(iic_wdt),
    .IIC_RAK_IN(iic_rak), .IIC_WDA_IN(iic_wda), .IIC_RVL_IN(iic_rvl),
    .IIC_RDT_IN(iic_rdt), .IIC_BSY_IN(iic_bsy), .IIC_ERR_IN(iic_err)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic flag_fail(input string name, input logic [63:0] actual);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got 0x%0h, expected nothing", name, actual);
  endtask

  function automatic logic [31:0] bus_rec(input logic ast, input logic rnw, input logic [6:0] dad,
                                          input logic [7:0] b0, input logic [7:0] b1);
    return {6'd0, ast, rnw, 1'b0, dad, b0, b1};
  endfunction

  function automatic logic [63:0] all_outputs();
    return {reg_bsy, reg_ack, reg_rdt, reg_err, reg_tmo, iic_req, iic_ast, iic_rnw, iic_num, iic_dad, iic_wdt};
  endfunction

  // Host response monitor: every ACK pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && reg_ack) begin
      ack_count++;
      if (sb_exp.size() == 0) flag_fail("unexpected_ack", {reg_rdt, reg_err, reg_tmo});
      else check_output("ack_resp", {reg_rdt, reg_err, reg_tmo}, sb_exp.pop_front());
    end
  end

  // Core stub: acks a request, plays out the bus phase and logs what it was asked to do.
  initial begin : core_stub
    logic       s_ast, s_rnw;
    logic [6:0] s_dad;
    logic [7:0] b0, b1;
    logic [31:0] rec;
    forever begin
      @(posedge clock); #1;
      if (stub_hang) iic_bsy = 1'b1;
      else if (iic_req) begin
        s_ast = iic_ast; s_rnw = iic_rnw; s_dad = iic_dad; b0 = iic_wdt; b1 = 8'h00;
        iic_err = 1'b0; iic_rak = 1'b1; iic_bsy = 1'b1;
        @(posedge clock); #1;
        iic_rak = 1'b0;
        if (s_ast) begin
          repeat (2) @(posedge clock); #1;
          iic_err = as_nack;
        end else if (s_rnw) begin
          b0 = 8'h00;
          repeat (rd_hold) @(posedge clock); #1;
          iic_rvl = 1'b1; iic_rdt = rd_data; b1 = rd_data;
          @(posedge clock); #1;
          iic_rvl = 1'b0;
        end else begin
          @(posedge clock); #1; iic_wda = 1'b1;
          @(posedge clock); #1; iic_wda = 1'b0; b1 = iic_wdt;
          @(posedge clock); #1; iic_wda = 1'b1;
          @(posedge clock); #1; iic_wda = 1'b0;
        end
        iic_bsy = 1'b0;
        rec = bus_rec(s_ast, s_rnw, s_dad, b0, b1);
        if (bus_exp.size() == 0) flag_fail("unexpected_bus", rec);
        else check_output("bus_txn", rec, bus_exp.pop_front());
      end else iic_bsy = 1'b0;
    end
  end

  task automatic apply_stimulus(input logic rnw, input logic [6:0] dad, input logic [7:0] adr,
                                input logic [7:0] wdt, input logic hold);
    reg_rnw = rnw; reg_dad = dad; reg_adr = adr; reg_wdt = wdt; reg_req = 1'b1;
    @(posedge clock); #1;
    check_output("bsy_after_accept", reg_bsy, 1'b1);
    if (!hold) reg_req = 1'b0;
  endtask

  // Waits for the ACK pulse (dropping a held request when it shows), then checks BSY falls.
  task automatic wait_ack(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (reg_ack) begin seen = 1; reg_req = 1'b0; end
      else begin @(posedge clock); #1; end
    end
    reg_req = 1'b0;
    if (!seen) flag_fail("ack_timeout", 64'(budget));
    @(posedge clock); #1;
    check_output("bsy_after_ack", reg_bsy, 1'b0);
  endtask

  initial begin : global_limit
    #2_000_000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin : main
    int lat;
    repeat (3) @(posedge clock);
    #1;
    check_output("reset_outputs", all_outputs(), 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;
    check_output("idle_outputs", all_outputs(), 64'd0);

    // Plain write.
    bus_exp.push_back(bus_rec(1'b0, 1'b0, 7'h50, 8'h12, 8'hA5));
    sb_exp.push_back({8'h00, 1'b0, 1'b0});
    apply_stimulus(1'b0, 7'h50, 8'h12, 8'hA5, 1'b0);
    wait_ack(100);

    // Read: address-set then one data byte.
    rd_data = 8'h5C;
    bus_exp.push_back(bus_rec(1'b1, 1'b0, 7'h50, 8'h34, 8'h00));
    bus_exp.push_back(bus_rec(1'b0, 1'b1, 7'h50, 8'h00, 8'h5C));
    sb_exp.push_back({8'h5C, 1'b0, 1'b0});
    apply_stimulus(1'b1, 7'h50, 8'h34, 8'h00, 1'b0);
    wait_ack(100);

    // Address NACK: read phase skipped, previous read data kept.
    as_nack = 1'b1;
    bus_exp.push_back(bus_rec(1'b1, 1'b0, 7'h51, 8'h40, 8'h00));
    sb_exp.push_back({8'h5C, 1'b1, 1'b0});
    apply_stimulus(1'b1, 7'h51, 8'h40, 8'h00, 1'b0);
    wait_ack(100);
    as_nack = 1'b0;

    // Request held high throughout: only one access may result.
    bus_exp.push_back(bus_rec(1'b0, 1'b0, 7'h22, 8'h07, 8'h3C));
    sb_exp.push_back({8'h5C, 1'b0, 1'b0});
    apply_stimulus(1'b0, 7'h22, 8'h07, 8'h3C, 1'b1);
    wait_ack(100);

    // Core stuck busy: watchdog must end the access.
    stub_hang = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    sb_exp.push_back({8'h5C, 1'b1, 1'b1});
    apply_stimulus(1'b1, 7'h10, 8'h01, 8'h00, 1'b0);
    lat = 1;
    while (!reg_ack && lat < 400) begin
      @(posedge clock); #1;
      if (!reg_ack) lat++;
    end
    check_output("timeout_latency", 64'(lat), 64'd255);
    check_output("timeout_req_drop", iic_req, 1'b0);
    @(posedge clock); #1;
    check_output("bsy_after_timeout", reg_bsy, 1'b0);
    stub_hang = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // Reset during the read data phase: no ACK, everything cleared.
    rd_data = 8'h99; rd_hold = 20;
    bus_exp.push_back(bus_rec(1'b1, 1'b0, 7'h50, 8'h66, 8'h00));
    bus_exp.push_back(bus_rec(1'b0, 1'b1, 7'h50, 8'h00, 8'h99));
    sb_exp.push_back({8'h99, 1'b0, 1'b0});
    apply_stimulus(1'b1, 7'h50, 8'h66, 8'h00, 1'b0);
    lat = 0;
    while (!(iic_rnw && !iic_req && reg_bsy) && lat < 200) begin
      @(posedge clock); #1; lat++;
    end
    if (lat >= 200) flag_fail("rd_wait_reach", 64'(lat));
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    check_output("midreset_outputs", all_outputs(), 64'd0);
    sb_exp.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    lat = 0;
    while (iic_bsy && lat < 200) begin
      @(posedge clock); #1; lat++;
    end
    repeat (2) @(posedge clock);
    #1;
    check_output("rdt_after_stray_rvl", reg_rdt, 8'h00);
    rd_hold = 2;

    // Normal write after the reset.
    bus_exp.push_back(bus_rec(1'b0, 1'b0, 7'h3A, 8'hF0, 8'h0F));
    sb_exp.push_back({8'h00, 1'b0, 1'b0});
    apply_stimulus(1'b0, 7'h3A, 8'hF0, 8'h0F, 1'b0);
    wait_ack(100);

    repeat (10) @(posedge clock);
    #1;
    check_output("ack_count", 64'(ack_count), 64'd6);
    check_output("sb_pending", 64'(sb_exp.size()), 64'd0);
    check_output("bus_pending", 64'(bus_exp.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
